// File: rtl/ni_read_rqst_queue_pkg.sv
// Router / PE shared header: flit layout, router info codes and PE widths.
package ni_read_rqst_queue_pkg;

  localparam int unsigned ROUTER_WIDTH    = 36;
  localparam int unsigned INFO_MSB        = 35;
  localparam int unsigned INFO_LSB        = 32;
  localparam int unsigned ADDR_MSB        = 31;
  localparam int unsigned ADDR_LSB        = 16;
  localparam int unsigned DATA_MSB        = 15;
  localparam int unsigned DATA_LSB        = 0;

  localparam int unsigned PE_ACT_NO_WIDTH = 6;
  // Activation number lives in addr[6:1]
  localparam int unsigned ACT_ADDR_LSB    = ADDR_LSB + 1;

  typedef enum logic [3:0] {
    ROUTER_INFO_CONFIG        = 4'd0,
    ROUTER_INFO_CALC          = 4'd1,
    ROUTER_INFO_READ          = 4'd2,
    ROUTER_INFO_BROADCAST     = 4'd3,
    ROUTER_INFO_FIN_BROADCAST = 4'd4,
    ROUTER_INFO_FIN_COMP      = 4'd5,
    ROUTER_INFO_UV            = 4'd6
  } router_info_e;

endpackage

// File: rtl/ni_read_rqst_queue_sync_fifo.sv
// Generic circular FIFO with extra-MSB pointers; push while full is honoured only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ni_read_rqst_queue.sv
// NI read-request queue: buffers READ flit activation addresses and issues them when the router is ready.
// Optional simulation checks/prints under `NI_READ_RQST_QUEUE_CHECK_EN.
module ni_read_rqst_queue
  import ni_read_rqst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_data_valid,
  input  logic [ROUTER_WIDTH-1:0]    in_data,
  input  logic                       router_rdy,
  output logic                       read_rqst_read_en,
  output logic                       ni_read_rqst,
  output logic [PE_ACT_NO_WIDTH-1:0] ni_read_addr
);

  logic                       is_read;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [PE_ACT_NO_WIDTH-1:0] head;
  logic [PE_ACT_NO_WIDTH-1:0] act_addr;
  logic                       unused_flit;

  assign is_read  = in_data_valid && (in_data[INFO_MSB:INFO_LSB] == ROUTER_INFO_READ);
  assign act_addr = in_data[ACT_ADDR_LSB +: PE_ACT_NO_WIDTH];
  assign unused_flit = ^{in_data[ADDR_MSB:ACT_ADDR_LSB+PE_ACT_NO_WIDTH],
                         in_data[ACT_ADDR_LSB-1:DATA_LSB]};

  // A full queue still accepts a READ when the head issues in the same cycle
  assign pop  = !empty && router_rdy;
  assign push = is_read && (!full || pop);

  sync_fifo #(
    .WIDTH (PE_ACT_NO_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (act_addr),
    .full  (full),
    .empty (empty),
    .rdata (head)
  );

  assign read_rqst_read_en = pop;
  assign ni_read_rqst      = pop;
  assign ni_read_addr      = pop ? head : '0;

`ifdef NI_READ_RQST_QUEUE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst && is_read && full && !pop) begin
      $display("%0t ni_read_rqst_queue ERROR: READ pushed while full", $time);
      $finish;
    end
    if (!rst && pop) $display("%0t ni_read_rqst_queue issue ni_read_addr=%0d", $time, ni_read_addr);
  end
`endif

endmodule

// File: tb/tb_ni_read_rqst_queue.sv
// Self-checking bench for ni_read_rqst_queue against a queue-based reference model.
module tb_ni_read_rqst_queue;
  import ni_read_rqst_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_data_valid;
  logic [ROUTER_WIDTH-1:0]    in_data;
  logic                       router_rdy;
  logic                       read_rqst_read_en;
  logic                       ni_read_rqst;
  logic [PE_ACT_NO_WIDTH-1:0] ni_read_addr;

  int checks = 0;
  int errors = 0;

  logic [5:0] model[$];
  bit         obs_en, obs_rqst;
  logic [5:0] obs_addr;
  bit         exp_en;
  logic [5:0] exp_addr;
  bit         cur_v, cur_rdy, last_pushed;
  logic [3:0] cur_info;
  logic [15:0] cur_addr;

  always #5 clk = ~clk;

  ni_read_rqst_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .router_rdy        (router_rdy),
    .read_rqst_read_en (read_rqst_read_en),
    .ni_read_rqst      (ni_read_rqst),
    .ni_read_addr      (ni_read_addr)
  );

  // Drive one cycle's inputs, sample outputs and compute the model's expectation
  task automatic apply(input bit v, input logic [3:0] info, input logic [15:0] addr, input bit rdy);
    cur_v = v; cur_info = info; cur_addr = addr; cur_rdy = rdy;
    in_data_valid = v;
    in_data       = {info, addr, 16'($urandom)};
    router_rdy    = rdy;
    #1;
    obs_en   = read_rqst_read_en;
    obs_rqst = ni_read_rqst;
    obs_addr = ni_read_addr;
    exp_en   = (model.size() > 0) && rdy;
    exp_addr = exp_en ? model[0] : 6'd0;
  endtask

  // Apply the cycle's effect to the model and move to the next cycle
  task automatic advance();
    if (exp_en) void'(model.pop_front());
    last_pushed = cur_v && (cur_info == ROUTER_INFO_READ) && (model.size() < DEPTH);
    if (last_pushed) model.push_back(6'((cur_addr >> 1) & 16'h3F));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data_valid = 1'b0; in_data = '0; router_rdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (read_rqst_read_en !== 1'b0 || ni_read_rqst !== 1'b0 || ni_read_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset: en=%b rqst=%b addr=%0d, expected all 0", read_rqst_read_en, ni_read_rqst, ni_read_addr);
    end
    rst = 1'b0;
    model.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    apply(1'b1, ROUTER_INFO_READ, 16'h001A, 1'b1);
    checks++;
    if (obs_en !== 1'b0 || obs_addr !== 6'd0) begin
      errors++; $display("FAIL single_no_bypass: en=%b addr=%0d, expected en=0 addr=0", obs_en, obs_addr);
    end
    advance();
    apply(1'b0, ROUTER_INFO_READ, 16'h0000, 1'b1);
    checks++;
    if (obs_en !== 1'b1 || obs_rqst !== 1'b1 || obs_addr !== 6'd13) begin
      errors++; $display("FAIL single_issue: en=%b rqst=%b addr=%0d, expected en=1 rqst=1 addr=13", obs_en, obs_rqst, obs_addr);
    end
    advance();
    apply(1'b0, ROUTER_INFO_READ, 16'h0000, 1'b1);
    checks++;
    if (obs_en !== 1'b0 || obs_rqst !== 1'b0 || obs_addr !== 6'd0) begin
      errors++; $display("FAIL single_after: en=%b rqst=%b addr=%0d, expected all 0", obs_en, obs_rqst, obs_addr);
    end
    advance();
  endtask

  task automatic fill_stalled(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3);
    logic [15:0] addrs [4];
    addrs = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, ROUTER_INFO_READ, addrs[i], 1'b0);
      checks++;
      if (obs_en !== 1'b0 || obs_rqst !== 1'b0 || obs_addr !== 6'd0) begin
        errors++; $display("FAIL stall_hold[%0d]: en=%b addr=%0d, expected en=0 addr=0", i, obs_en, obs_addr);
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [5:0] want [4];
    want = '{6'd1, 6'd2, 6'd3, 6'd4};
    fill_stalled(16'h0002, 16'h0004, 16'h0006, 16'h0008);
    apply(1'b0, ROUTER_INFO_READ, 16'h0000, 1'b0);
    checks++;
    if (obs_en !== 1'b0) begin
      errors++; $display("FAIL stall_idle: en=%b, expected 0", obs_en);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, ROUTER_INFO_READ, 16'h0000, 1'b1);
      checks++;
      if (obs_en !== 1'b1 || obs_rqst !== 1'b1 || obs_addr !== want[i] || obs_addr !== exp_addr) begin
        errors++; $display("FAIL stall_drain[%0d]: en=%b addr=%0d, expected en=1 addr=%0d", i, obs_en, obs_addr, want[i]);
      end
      advance();
    end
  endtask

  task automatic test_full_push_pop();
    logic [5:0] want [5];
    int issues = 0;
    want = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd63};
    fill_stalled(16'h0002, 16'h0004, 16'h0006, 16'h0008);
    for (int i = 0; i < 6; i++) begin
      apply(i == 0, ROUTER_INFO_READ, 16'h007E, 1'b1);
      checks++;
      if (obs_en !== exp_en || obs_addr !== exp_addr || (i < 5 && obs_addr !== want[i])) begin
        errors++; $display("FAIL full_push_pop[%0d]: en=%b addr=%0d, expected en=%b addr=%0d", i, obs_en, obs_addr, exp_en, exp_addr);
      end
      if (obs_en) issues++;
      advance();
    end
    checks++;
    if (issues != 5) begin
      errors++; $display("FAIL full_push_pop_count: issues=%0d, expected 5", issues);
    end
  endtask

  task automatic test_ignore();
    logic [3:0] codes [3];
    codes = '{ROUTER_INFO_CONFIG, ROUTER_INFO_CALC, ROUTER_INFO_BROADCAST};
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, codes[i % 3], 16'($urandom), 1'b1);
      checks++;
      if (obs_en !== 1'b0 || obs_rqst !== 1'b0 || obs_addr !== 6'd0) begin
        errors++; $display("FAIL ignore[%0d]: en=%b addr=%0d, expected en=0 addr=0", i, obs_en, obs_addr);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, ROUTER_INFO_READ, 16'(2 * (i + 10)), 1'b0);
      advance();
    end
    apply(1'b0, ROUTER_INFO_READ, 16'h0000, 1'b1);
    checks++;
    if (obs_en !== 1'b1 || obs_addr !== 6'd10) begin
      errors++; $display("FAIL reset_mid_pre: en=%b addr=%0d, expected en=1 addr=10", obs_en, obs_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (read_rqst_read_en !== 1'b0 || ni_read_rqst !== 1'b0 || ni_read_addr !== 6'd0) begin
      errors++; $display("FAIL reset_mid_async: en=%b rqst=%b addr=%0d, expected all 0", read_rqst_read_en, ni_read_rqst, ni_read_addr);
    end
    model.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, ROUTER_INFO_READ, 16'h0000, 1'b1);
      checks++;
      if (obs_en !== 1'b0 || obs_addr !== 6'd0) begin
        errors++; $display("FAIL reset_mid_after[%0d]: en=%b addr=%0d, expected en=0 addr=0", i, obs_en, obs_addr);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [5:0] pushed[$];
    logic [5:0] issued[$];
    int cyc = 0;
    bit v, rdy;
    logic [3:0] info;
    while ((pushed.size() < 8 || model.size() > 0) && cyc < 300) begin
      v    = (pushed.size() < 8) && ($urandom_range(0, 1) == 1);
      info = ($urandom_range(0, 4) == 0) ? ROUTER_INFO_CALC : ROUTER_INFO_READ;
      rdy  = ($urandom_range(0, 2) != 0);
      if (v && info == ROUTER_INFO_READ && model.size() == DEPTH && !rdy) v = 1'b0;
      apply(v, info, 16'($urandom), rdy);
      checks++;
      if (obs_en !== exp_en || obs_rqst !== exp_en || obs_addr !== exp_addr) begin
        errors++; $display("FAIL random[%0d]: en=%b addr=%0d, expected en=%b addr=%0d", cyc, obs_en, obs_addr, exp_en, exp_addr);
      end
      if (obs_en) issued.push_back(obs_addr);
      advance();
      if (last_pushed) pushed.push_back(6'((cur_addr >> 1) & 16'h3F));
      cyc++;
    end
    checks++;
    if (cyc >= 300 || issued.size() != pushed.size()) begin
      errors++; $display("FAIL random_count: issued=%0d, expected %0d (cycles %0d)", issued.size(), pushed.size(), cyc);
    end else begin
      for (int i = 0; i < pushed.size(); i++) begin
        checks++;
        if (issued[i] !== pushed[i]) begin
          errors++; $display("FAIL random_order[%0d]: got %0d, expected %0d", i, issued[i], pushed[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_full_push_pop();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
